cache_ctrl: RTL

Command sequencer that sits directly upstream of the cache storage array (the key/value cell block with registered lookup). It accepts GET/PUT/DEL requests over a valid/ready interface and drives the array's lookup key. It waits out the array's one-cycle registered lookup, then issues the write or delete pulse to the right one-hot slot and returns a status and value over a valid/ready response interface. It is the only master of the storage array.

---
 rtl/cache_ctrl_if.sv | 39 +++
 rtl/cache_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: request/response handshake plus storage-array bus around cache_ctrl.
// slave is the controller side; master is the requester together with the array.
interface cache_ctrl_if #(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH = 16,
  parameter int VALUE_WIDTH = 64
);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [KEY_WIDTH-1:0] cmd_key;
  logic [VALUE_WIDTH-1:0] cmd_value;
  logic rsp_valid;
  logic rsp_ready;
  logic [1:0] rsp_status;
  logic [VALUE_WIDTH-1:0] rsp_value;
  logic mem_write;
  logic mem_delete;
  logic mem_select_by_index;
  logic [KEY_WIDTH-1:0] mem_key;
  logic [VALUE_WIDTH-1:0] mem_value;
  logic [NUM_ENTRIES-1:0] mem_index;
  logic [VALUE_WIDTH-1:0] mem_value_out;
  logic [NUM_ENTRIES-1:0] mem_index_out;
  logic mem_hit;
  logic [NUM_ENTRIES-1:0] mem_used_entries;
  modport slave (
    input cmd_valid, cmd_op, cmd_key, cmd_value, rsp_ready,
    input mem_value_out, mem_index_out, mem_hit, mem_used_entries,
    output cmd_ready, rsp_valid, rsp_status, rsp_value,
    output mem_write, mem_delete, mem_select_by_index, mem_key, mem_value, mem_index
  );
  modport master (
    output cmd_valid, cmd_op, cmd_key, cmd_value, rsp_ready,
    output mem_value_out, mem_index_out, mem_hit, mem_used_entries,
    input cmd_ready, rsp_valid, rsp_status, rsp_value,
    input mem_write, mem_delete, mem_select_by_index, mem_key, mem_value, mem_index
  );
endinterface

// File: rtl/cache_ctrl.sv
// cache_ctrl: one-at-a-time GET/PUT/DEL sequencer that masters the key/value storage array.
// Defining CACHE_CTRL_STATS_EN adds saturating hit/miss counters with stat_clr.
module cache_ctrl #(
  parameter int NUM_ENTRIES = 16,
  parameter int KEY_WIDTH = 16,
  parameter int VALUE_WIDTH = 64
) (
  input logic clk,
  input logic rst_n,
`ifdef CACHE_CTRL_STATS_EN
  input logic stat_clr,
  output logic [15:0] stat_hits,
  output logic [15:0] stat_misses,
`endif
  cache_ctrl_if.slave bus
);
  localparam logic [1:0] OP_GET = 2'b00, OP_PUT = 2'b01, OP_DEL = 2'b10, OP_RSVD = 2'b11;
  localparam logic [1:0] ST_OK = 2'b00, ST_MISS = 2'b01, ST_FULL = 2'b10, ST_ERR = 2'b11;
  typedef enum logic [2:0] {IDLE, LOOKUP, EVAL, EXEC, RESP} state_t;
  state_t state;
  logic [1:0] op;
  logic [KEY_WIDTH-1:0] key;
  logic [VALUE_WIDTH-1:0] value;
  logic [NUM_ENTRIES-1:0] free_oh;
  logic done_in_eval;
  // lowest clear bit of used: ~x & (x + 1)
  assign free_oh = ~bus.mem_used_entries & (bus.mem_used_entries + NUM_ENTRIES'(1));
  assign done_in_eval = op == OP_GET || !bus.mem_hit && (op == OP_DEL || free_oh == '0);
  assign bus.mem_key = key;
  assign bus.mem_value = value;
  assign bus.mem_select_by_index = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op <= '0;
      key <= '0;
      value <= '0;
      bus.cmd_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_status <= ST_OK;
      bus.rsp_value <= '0;
      bus.mem_write <= 1'b0;
      bus.mem_delete <= 1'b0;
      bus.mem_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_ready && bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            op <= bus.cmd_op;
            key <= bus.cmd_key;
            value <= bus.cmd_value;
            if (bus.cmd_op == OP_RSVD || bus.cmd_key == '0) begin
              state <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_status <= ST_ERR;
            end else state <= LOOKUP;
          end else bus.cmd_ready <= 1'b1;
        end
        LOOKUP: state <= EVAL;
        EVAL: begin
          if (done_in_eval) begin
            state <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_status <= op == OP_GET ? (bus.mem_hit ? ST_OK : ST_MISS) : op == OP_DEL ? ST_MISS : ST_FULL;
            bus.rsp_value <= op == OP_GET && bus.mem_hit ? bus.mem_value_out : '0;
          end else begin
            state <= EXEC;
            bus.mem_write <= op == OP_PUT;
            bus.mem_delete <= op == OP_DEL;
            bus.mem_index <= bus.mem_hit ? bus.mem_index_out : free_oh;
          end
        end
        EXEC: begin
          state <= RESP;
          bus.mem_write <= 1'b0;
          bus.mem_delete <= 1'b0;
          bus.mem_index <= '0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_status <= ST_OK;
          bus.rsp_value <= '0;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_status <= ST_OK;
            bus.rsp_value <= '0;
            bus.cmd_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef CACHE_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits <= '0;
      stat_misses <= '0;
    end else if (stat_clr) begin
      stat_hits <= '0;
      stat_misses <= '0;
    end else if (state == EVAL) begin
      if (bus.mem_hit && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
      if (!bus.mem_hit && stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
    end
  end
`endif
endmodule
